fht_but: RTL and testbench
==========================

Name: fht_but

Overview:
- Two-point radix-2 butterfly for the fast Hartley transform (FHT) datapath.
- Computes the twiddle term m = (cos·X1 + sin·X2)/W_MAX.
- Combines m with X0: Y0 = (X0 + m)/2 and Y1 = (X0 − m)/2. The /2 keeps each FHT stage in range.
- Instantiated once per butterfly slot in the FHT stage pipeline. It has no handshake and accepts one operation per clock.

Parameters:
- D_BIT, 16: data width of X0/X1/X2/Y0/Y1, signed two's complement. D_MAX = 2^(D_BIT−1).
- W_BIT, 16: twiddle width of iSIN/iCOS, signed two's complement.
- HALF_W_MAX, 8192: half of the twiddle unit scale. W_MAX = 2·HALF_W_MAX.
  - Must be a power of two.
  - Must satisfy W_MAX ≤ 2^(W_BIT−1)−1, so that +W_MAX and −W_MAX are both representable.

Ports:
- iCLK  in  1  clock; all registers update on the rising edge.
- iRESET  in  1  reset, synchronous, active-high.
- iX_0  in  D_BIT  signed direct operand. Sampled one cycle after its X1/X2/coefficient set.
- iX_1  in  D_BIT  signed operand multiplied by cos.
- iX_2  in  D_BIT  signed operand multiplied by sin.
- iSIN  in  W_BIT  signed twiddle sine, scaled by W_MAX.
- iCOS  in  W_BIT  signed twiddle cosine, scaled by W_MAX.
- oY_0  out  D_BIT  signed sum output, registered.
- oY_1  out  D_BIT  signed difference output, registered.

Behaviour:
- Stage 1, at rising edge k:
  - Full-precision sum S = iCOS·iX_1 + iSIN·iX_2, width D_BIT+W_BIT+1 (no overflow possible).
  - Normalise with round-half-up: ROUND_SUM_MUL = (S + HALF_W_MAX) >>> log2(W_MAX), arithmetic shift.
  - ROUND_SUM_MUL is a register of width D_BIT+1 and must keep that name (benches probe it hierarchically).
  - D_BIT+1 is sufficient because |m| ≤ √2·D_MAX when cos²+sin² ≤ W_MAX².
- Stage 2, at rising edge k+1:
  - Uses iX_0 present at edge k+1 together with the registered ROUND_SUM_MUL.
  - A = iX_0 + m and B = iX_0 − m, each D_BIT+2 bits.
  - oY_0 = (A+1)>>>1 and oY_1 = (B+1)>>>1 (round-half-up).
- Latency: X1/X2/SIN/COS to output is 2 edges; X0 to output is 1 edge. One operation per cycle, fully pipelined, no stalls.
- Accuracy: each output must be within |err| < 1 of the ideal real value (X0 ± (cos·X1+sin·X2)/W_MAX)/2. The worst case is 0.25 + 0.5.
- Saturation: outputs clamp to [−D_MAX, D_MAX−1] when the rounded result exceeds range. No wrap-around. Inputs at extreme values, e.g. 45° twiddle with X1=X2=D_MAX−1, must saturate and never wrap.
- Reset: while iRESET=1 at an edge, ROUND_SUM_MUL, oY_0 and oY_1 all clear to 0.
  - Reset has priority over data.
  - The first valid output appears on the second edge after iRESET deasserts.
  - Reset mid-stream discards all in-flight operations.
- Combinational paths from inputs to outputs are forbidden; outputs are register-driven only.

Decomposition:
- Shared package fht_pkg holds:
  - Default constants D_BIT, W_BIT, HALF_W_MAX.
  - Derived constants W_MAX, D_MAX, and the log2 shift amount.
  - A saturate-to-D_BIT function, reused by other FHT stages.
- One sub-module is natural: fht_but_mul, containing the two multipliers, the adder and the rounding register (stage 1). fht_but adds stage 2, rounding and saturation.

Test Plan:
- Reset: iRESET=1 for 2 cycles with random inputs -> oY_0=oY_1=0 and ROUND_SUM_MUL=0. First valid output appears 2 edges after release.
- 0° twiddle: cos=16384, sin=0, X1=1000, X2=500; next cycle X0=2000 -> m=1000, Y0=1500, Y1=500.
- 90° twiddle, negative rounding: cos=0, sin=16384, X2=−3; next cycle X0=0 -> m=−3, Y0=−1, Y1=2.
- 45° saturation: cos=sin=11585, X1=X2=32767; then X0=32767 -> m=46339, Y0 saturates to 32767, Y1=−6786.
- Spec-angle sweep: the 8 multiples of 45°, combined with X0/X1/X2 each in {−32768, 32767} -> every output within |err|<1 of the ideal value or exactly saturated. No wrap.
- Back-to-back random stream: `NUM_OF_RPT`-style random X and unit-circle twiddles, a new set every cycle -> every output matches its own operand set with |err|<1 and 2-cycle alignment. A reset asserted mid-stream zeroes the outputs on the next edge.

Source files
------------

// File: rtl/fht_pkg.sv
// Shared constants and helpers for the fast Hartley transform (FHT) datapath.
// Every FHT stage imports this package so that all stages use the same scaling.
package fht_pkg;

    localparam int D_BIT      = 16;
    localparam int W_BIT      = 16;
    localparam int HALF_W_MAX = 8192;

    // HALF_W_MAX must be a power of two, so that the divide by W_MAX is a plain shift.
    localparam int W_MAX   = 2 * HALF_W_MAX;
    localparam int D_MAX   = 1 << (D_BIT - 1);
    localparam int W_SHIFT = $clog2(W_MAX);

    localparam int SAT_W = 64;

    // Clamp a sign-extended value into the signed range of 'bits' bits.
    function automatic logic signed [SAT_W-1:0] sat_to_bits(
        input logic signed [SAT_W-1:0] x,
        input int                      bits
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/fht_but_mul.sv
// Butterfly stage 1: twiddle products, their sum, and the round-half-up
// normalisation by W_MAX into the ROUND_SUM_MUL register.
module fht_but_mul
    import fht_pkg::*;
#(
    parameter int D_BIT      = fht_pkg::D_BIT,
    parameter int W_BIT      = fht_pkg::W_BIT,
    parameter int HALF_W_MAX = fht_pkg::HALF_W_MAX
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic signed [D_BIT-1:0] iX_1,
    input  logic signed [D_BIT-1:0] iX_2,
    input  logic signed [W_BIT-1:0] iSIN,
    input  logic signed [W_BIT-1:0] iCOS,
    output logic signed [D_BIT:0]   oROUND_SUM_MUL
);

    localparam int P_BIT = D_BIT + W_BIT + 1;
    localparam int SHIFT = $clog2(2 * HALF_W_MAX);

    logic signed [P_BIT-1:0] cos_ext;
    logic signed [P_BIT-1:0] sin_ext;
    logic signed [P_BIT-1:0] x1_ext;
    logic signed [P_BIT-1:0] x2_ext;
    logic signed [P_BIT-1:0] sum_s;
    logic signed [P_BIT-1:0] rounded;
    logic signed [D_BIT:0]   m_d;
    logic signed [D_BIT:0]   ROUND_SUM_MUL;
    logic                    unused_rounded;

    always_comb begin
        cos_ext = {{(P_BIT - W_BIT){iCOS[W_BIT-1]}}, iCOS};
        sin_ext = {{(P_BIT - W_BIT){iSIN[W_BIT-1]}}, iSIN};
        x1_ext  = {{(P_BIT - D_BIT){iX_1[D_BIT-1]}}, iX_1};
        x2_ext  = {{(P_BIT - D_BIT){iX_2[D_BIT-1]}}, iX_2};
        sum_s   = cos_ext * x1_ext + sin_ext * x2_ext;
        // Adding half an LSB before the arithmetic shift gives round-half-up.
        rounded = (sum_s + P_BIT'(HALF_W_MAX)) >>> SHIFT;
        // |m| <= sqrt(2)*D_MAX for a unit-circle twiddle, so D_BIT+1 bits hold it.
        m_d     = rounded[D_BIT:0];
    end

    assign unused_rounded = ^rounded[P_BIT-1:D_BIT+1];

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            ROUND_SUM_MUL <= '0;
        end else begin
            ROUND_SUM_MUL <= m_d;
        end
    end

    assign oROUND_SUM_MUL = ROUND_SUM_MUL;

endmodule

// File: rtl/fht_but.sv
// Radix-2 FHT butterfly: Y0 = (X0 + m)/2, Y1 = (X0 - m)/2 with
// m = (cos*X1 + sin*X2)/W_MAX, rounded half-up and saturated to D_BIT.
module fht_but
    import fht_pkg::*;
#(
    parameter int D_BIT      = fht_pkg::D_BIT,
    parameter int W_BIT      = fht_pkg::W_BIT,
    parameter int HALF_W_MAX = fht_pkg::HALF_W_MAX
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic signed [D_BIT-1:0] iX_0,
    input  logic signed [D_BIT-1:0] iX_1,
    input  logic signed [D_BIT-1:0] iX_2,
    input  logic signed [W_BIT-1:0] iSIN,
    input  logic signed [W_BIT-1:0] iCOS,
    output logic signed [D_BIT-1:0] oY_0,
    output logic signed [D_BIT-1:0] oY_1
);

    logic signed [D_BIT:0]   ROUND_SUM_MUL;
    logic signed [D_BIT+1:0] x0_ext;
    logic signed [D_BIT+1:0] m_ext;
    logic signed [D_BIT+1:0] sum_a;
    logic signed [D_BIT+1:0] dif_b;
    logic signed [D_BIT+2:0] sum_r;
    logic signed [D_BIT+2:0] dif_r;
    logic signed [SAT_W-1:0] sum_sat;
    logic signed [SAT_W-1:0] dif_sat;
    logic signed [D_BIT-1:0] y0_d;
    logic signed [D_BIT-1:0] y1_d;
    logic signed [D_BIT-1:0] y0_q;
    logic signed [D_BIT-1:0] y1_q;
    logic                    unused_bits;

    fht_but_mul #(
        .D_BIT      (D_BIT),
        .W_BIT      (W_BIT),
        .HALF_W_MAX (HALF_W_MAX)
    ) u_mul (
        .iCLK           (iCLK),
        .iRESET         (iRESET),
        .iX_1           (iX_1),
        .iX_2           (iX_2),
        .iSIN           (iSIN),
        .iCOS           (iCOS),
        .oROUND_SUM_MUL (ROUND_SUM_MUL)
    );

    always_comb begin
        x0_ext  = {{2{iX_0[D_BIT-1]}}, iX_0};
        m_ext   = {ROUND_SUM_MUL[D_BIT], ROUND_SUM_MUL};
        sum_a   = x0_ext + m_ext;
        dif_b   = x0_ext - m_ext;
        // One extra bit keeps the +1 rounding carry; dropping bit 0 is the >>>1.
        sum_r   = {sum_a[D_BIT+1], sum_a} + (D_BIT+3)'(1);
        dif_r   = {dif_b[D_BIT+1], dif_b} + (D_BIT+3)'(1);
        sum_sat = sat_to_bits({{(SAT_W-D_BIT-2){sum_r[D_BIT+2]}}, sum_r[D_BIT+2:1]}, D_BIT);
        dif_sat = sat_to_bits({{(SAT_W-D_BIT-2){dif_r[D_BIT+2]}}, dif_r[D_BIT+2:1]}, D_BIT);
        y0_d    = sum_sat[D_BIT-1:0];
        y1_d    = dif_sat[D_BIT-1:0];
    end

    assign unused_bits = ^{sum_r[0], dif_r[0], sum_sat[SAT_W-1:D_BIT], dif_sat[SAT_W-1:D_BIT]};

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            y0_q <= '0;
            y1_q <= '0;
        end else begin
            y0_q <= y0_d;
            y1_q <= y1_d;
        end
    end

    assign oY_0 = y0_q;
    assign oY_1 = y1_q;

endmodule

// File: tb/tb_fht_but.sv
// Directed bench for the FHT butterfly: reset, hand-computed twiddle cases,
// an 8-angle extreme-value sweep and a back-to-back random stream.
module tb_fht_but;

    localparam int NUM_OF_RPT = 40;
    localparam real W_MAX_R = 16384.0;

    logic               iCLK = 1'b0;
    logic               iRESET = 1'b1;
    logic signed [15:0] iX_0 = '0;
    logic signed [15:0] iX_1 = '0;
    logic signed [15:0] iX_2 = '0;
    logic signed [15:0] iSIN = '0;
    logic signed [15:0] iCOS = '0;
    logic signed [15:0] oY_0;
    logic signed [15:0] oY_1;

    int total = 0;
    int bad   = 0;

    fht_but dut (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iX_0   (iX_0),
        .iX_1   (iX_1),
        .iX_2   (iX_2),
        .iSIN   (iSIN),
        .iCOS   (iCOS),
        .oY_0   (oY_0),
        .oY_1   (oY_1)
    );

    always #5 iCLK = ~iCLK;

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Within |err|<1 of the real-valued butterfly, or clamped at the rail it overshot.
    task automatic check_tol(input string tag, input int obs, input real ideal);
        real err;
        bit  ok;
        err = $itor(obs) - ideal;
        ok  = (err < 1.0 && err > -1.0) ||
              (ideal > 32767.0 && obs == 32767) ||
              (ideal < -32768.0 && obs == -32768);
        total++;
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s: got %0d ideal %f", tag, obs, ideal);
        end
    endtask

    function automatic real ideal_m(input int c, input int s, input int x1, input int x2);
        return ($itor(c) * $itor(x1) + $itor(s) * $itor(x2)) / W_MAX_R;
    endfunction

    int ang_c[8] = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
    int ang_s[8] = '{0, 11585, 16384, 11585, 0, -11585, -16384, -11585};

    int st_c[NUM_OF_RPT];
    int st_s[NUM_OF_RPT];
    int st_x0[NUM_OF_RPT];
    int st_x1[NUM_OF_RPT];
    int st_x2[NUM_OF_RPT];

    initial begin
        real m, phi;
        int  x0, x1, x2;

        // Reset held for two edges with random inputs.
        iRESET = 1'b1;
        iX_0 = 16'($urandom); iX_1 = 16'($urandom); iX_2 = 16'($urandom);
        iSIN = 16'($urandom); iCOS = 16'($urandom);
        step();
        iX_0 = 16'($urandom); iX_1 = 16'($urandom); iX_2 = 16'($urandom);
        step();
        check("rst_y0", oY_0, 0);
        check("rst_y1", oY_1, 0);
        check("rst_rsm", dut.ROUND_SUM_MUL, 0);

        // 0 deg: first valid output two edges after release.
        iRESET = 1'b0;
        iCOS = 16384; iSIN = 0; iX_1 = 1000; iX_2 = 500; iX_0 = 0;
        step();
        check("deg0_rsm", dut.ROUND_SUM_MUL, 1000);
        check("deg0_early_y0", oY_0, 0);
        iX_0 = 2000;
        step();
        check("deg0_y0", oY_0, 1500);
        check("deg0_y1", oY_1, 500);

        // 90 deg with a negative half-way rounding.
        iCOS = 0; iSIN = 16384; iX_1 = 777; iX_2 = -3; iX_0 = 0;
        step();
        check("deg90_rsm", dut.ROUND_SUM_MUL, -3);
        iX_0 = 0;
        step();
        check("deg90_y0", oY_0, -1);
        check("deg90_y1", oY_1, 2);

        // 45 deg at full scale: Y0 must saturate, not wrap.
        iCOS = 11585; iSIN = 11585; iX_1 = 32767; iX_2 = 32767; iX_0 = 0;
        step();
        check("deg45_rsm", dut.ROUND_SUM_MUL, 46339);
        iX_0 = 32767;
        step();
        check("deg45_y0", oY_0, 32767);
        check("deg45_y1", oY_1, -6786);

        // Eight multiples of 45 deg with every extreme operand combination.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                x0 = b[0] ? 32767 : -32768;
                x1 = b[1] ? 32767 : -32768;
                x2 = b[2] ? 32767 : -32768;
                iCOS = 16'(ang_c[a]); iSIN = 16'(ang_s[a]);
                iX_1 = 16'(x1); iX_2 = 16'(x2); iX_0 = 0;
                step();
                iX_0 = 16'(x0);
                step();
                m = ideal_m(ang_c[a], ang_s[a], x1, x2);
                check_tol($sformatf("sweep_y0_a%0d_v%0d", a, b), oY_0, ($itor(x0) + m) / 2.0);
                check_tol($sformatf("sweep_y1_a%0d_v%0d", a, b), oY_1, ($itor(x0) - m) / 2.0);
            end
        end

        // Back-to-back stream: a new operand set every cycle, X0 one cycle behind its set.
        iX_0 = 0;
        for (int i = 0; i <= NUM_OF_RPT; i++) begin
            if (i < NUM_OF_RPT) begin
                phi      = $itor($urandom_range(0, 3599)) * 3.14159265358979 / 1800.0;
                st_c[i]  = $rtoi(W_MAX_R * $cos(phi));
                st_s[i]  = $rtoi(W_MAX_R * $sin(phi));
                st_x0[i] = int'($urandom_range(0, 65535)) - 32768;
                st_x1[i] = int'($urandom_range(0, 65535)) - 32768;
                st_x2[i] = int'($urandom_range(0, 65535)) - 32768;
                iCOS = 16'(st_c[i]); iSIN = 16'(st_s[i]);
                iX_1 = 16'(st_x1[i]); iX_2 = 16'(st_x2[i]);
            end
            if (i >= 1) begin
                iX_0 = 16'(st_x0[i-1]);
            end
            step();
            if (i >= 1) begin
                m = ideal_m(st_c[i-1], st_s[i-1], st_x1[i-1], st_x2[i-1]);
                check_tol($sformatf("stream_y0_%0d", i-1), oY_0, ($itor(st_x0[i-1]) + m) / 2.0);
                check_tol($sformatf("stream_y1_%0d", i-1), oY_1, ($itor(st_x0[i-1]) - m) / 2.0);
            end
        end

        // Mid-stream reset: clears outputs at once and discards the in-flight product.
        iCOS = 16384; iSIN = 0; iX_1 = 20000; iX_2 = 0; iX_0 = 30000;
        step();
        iRESET = 1'b1;
        iX_1 = 12345; iX_0 = 30000;
        step();
        check("midrst_y0", oY_0, 0);
        check("midrst_y1", oY_1, 0);
        check("midrst_rsm", dut.ROUND_SUM_MUL, 0);
        iRESET = 1'b0;
        iX_0 = 100;
        step();
        check("flush_y0", oY_0, 50);
        check("flush_y1", oY_1, 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
